// File: rtl/rx_tx_pkg.sv
// Shared Ethernet RX/TX constants, framer state type and the reflected CRC-32 byte step.
package rx_tx_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    // Residue left in the register after running CRC over data plus a correct FCS
    localparam logic [31:0] CRC32_CONSTANT = 32'hDEBB20E3;
    localparam int          MIN_FRAME_SIZE = 64;
    localparam int          MAX_FRAME_SIZE = 1518;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_t;

    function automatic logic [31:0] crc32_next(input logic [7:0] d, input logic [31:0] c);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_rx_delay_line.sv
// Fixed-depth byte shift register with per-entry valid bits; holds back the trailing FCS bytes.
module eth_rx_delay_line #(
    parameter int DEPTH = 5,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n_in,
    input  logic         push,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] data;
    logic [DEPTH-1:0]        vld;

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data <= '0;
            vld  <= '0;
        end else if (flush) begin
            vld  <= '0;
        end else if (push) begin
            data <= {data[DEPTH-2:0], din};
            vld  <= {vld[DEPTH-2:0], 1'b1};
        end
    end

    assign full = &vld;
    assign dout = data[DEPTH-1];

endmodule

// File: rtl/eth_rx_framer.sv
// Byte-wide Ethernet RX framer: preamble/SFD detect, CRC-32 check, FCS strip, sop/eop payload stream.
// Optional RX_LEN_CHECK_EN adds a post-SFD byte counter that flags frames outside 64..1518 bytes.
module eth_rx_framer
    import rx_tx_pkg::*;
#(
    parameter int          PREAMBLE_MIN = 6,
    parameter logic [31:0] CRC_INIT     = 32'hFFFFFFFF
) (
    input  logic       clk,
    input  logic       rst_n_in,
    input  logic       rx_dv,
    input  logic       rx_er,
    input  logic [7:0] rxd,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_err,
    output logic       stat_frame_ok,
    output logic       stat_frame_err
);

    rx_state_t   state, state_nxt;
    logic [2:0]  pre_cnt;
    logic [31:0] crc;
    logic        sticky_err;
    logic        sop_pend;
    logic        dl_full;
    logic [7:0]  dl_dout;

    logic is_pre, sfd_ok, push, emit, frame_end, emit_eop, frame_bad, len_bad;

    assign is_pre = (rxd == PREAMBLE_BYTE);
    assign sfd_ok = (state == PREAMBLE) && rx_dv && (rxd == SFD_BYTE) &&
                    (int'(pre_cnt) >= PREAMBLE_MIN);

`ifdef RX_LEN_CHECK_EN
    logic [10:0] len_cnt;

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in)                      len_cnt <= '0;
        else if (sfd_ok)                    len_cnt <= '0;
        else if (push && len_cnt != 11'h7FF) len_cnt <= len_cnt + 11'd1;
    end

    assign len_bad = (len_cnt < 11'(MIN_FRAME_SIZE)) || (len_cnt > 11'(MAX_FRAME_SIZE));
`else
    assign len_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (rx_dv) state_nxt = is_pre ? PREAMBLE : DROP;
            PREAMBLE: begin
                if (!rx_dv)      state_nxt = IDLE;
                else if (is_pre) state_nxt = PREAMBLE;
                else if (sfd_ok) state_nxt = DATA;
                else             state_nxt = DROP;
            end
            DATA:     if (!rx_dv) state_nxt = IDLE;
            DROP:     if (!rx_dv) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        push      = (state == DATA) && rx_dv;
        emit      = push && dl_full;
        frame_end = (state == DATA) && !rx_dv;
        emit_eop  = frame_end && dl_full;
        frame_bad = sticky_err || (crc != CRC32_CONSTANT) || len_bad;
    end

    eth_rx_delay_line #(.DEPTH(5), .W(8)) u_dly (
        .clk      (clk),
        .rst_n_in (rst_n_in),
        .push     (push),
        .flush    (frame_end),
        .din      (rxd),
        .full     (dl_full),
        .dout     (dl_dout)
    );

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pre_cnt    <= '0;
            crc        <= CRC_INIT;
            sticky_err <= 1'b0;
            sop_pend   <= 1'b0;
        end else begin
            if (state == IDLE && rx_dv && is_pre)                     pre_cnt <= 3'd1;
            else if (state == PREAMBLE && rx_dv && is_pre && pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
            else if (state != PREAMBLE)                                pre_cnt <= '0;

            if (sfd_ok)    crc <= CRC_INIT;
            else if (push) crc <= crc32_next(rxd, crc);

            if (sfd_ok || frame_end) sticky_err <= 1'b0;
            else if (push && rx_er)  sticky_err <= 1'b1;

            if (sfd_ok)                sop_pend <= 1'b1;
            else if (emit || emit_eop) sop_pend <= 1'b0;
        end
    end

    // A runt never fills the line, so it only ever shows up as a stat error pulse
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_sop        <= 1'b0;
            out_eop        <= 1'b0;
            out_err        <= 1'b0;
            stat_frame_ok  <= 1'b0;
            stat_frame_err <= 1'b0;
        end else begin
            out_valid      <= emit || emit_eop;
            out_data       <= (emit || emit_eop) ? dl_dout : 8'h00;
            out_sop        <= (emit || emit_eop) && sop_pend;
            out_eop        <= emit_eop;
            out_err        <= emit_eop && frame_bad;
            stat_frame_ok  <= emit_eop && !frame_bad;
            stat_frame_err <= frame_end && (!dl_full || frame_bad);
        end
    end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Directed bench for eth_rx_framer with an expected-output scoreboard.
module tb_eth_rx_framer;
    import rx_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       rx_dv = 1'b0;
    logic       rx_er = 1'b0;
    logic [7:0] rxd = 8'h00;
    logic       out_valid, out_sop, out_eop, out_err, stat_frame_ok, stat_frame_err;
    logic [7:0] out_data;

    eth_rx_framer dut (
        .clk            (clk),
        .rst_n_in       (rst_n_in),
        .rx_dv          (rx_dv),
        .rx_er          (rx_er),
        .rxd            (rxd),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_err        (out_err),
        .stat_frame_ok  (stat_frame_ok),
        .stat_frame_err (stat_frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] stat_q[$];
    logic [7:0] frm[$];
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] s;
        if (out_valid) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL out_unexpected got data %h expected no output", out_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert ({out_data, out_sop, out_eop, out_err} === e) else begin
                    errors++;
                    $error("FAIL out_byte got %h/%b%b%b expected %h/%b%b%b", out_data, out_sop,
                           out_eop, out_err, e.data, e.sop, e.eop, e.err);
                end
            end
        end else begin
            checks++;
            assert ({out_sop, out_eop, out_err} === 3'b000) else begin
                errors++;
                $error("FAIL idle_flags got %b expected 000", {out_sop, out_eop, out_err});
            end
        end
        if (stat_frame_ok || stat_frame_err) begin
            checks++;
            assert (stat_q.size() > 0) else begin
                errors++;
                $error("FAIL stat_unexpected got %b%b expected no pulse", stat_frame_ok, stat_frame_err);
            end
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                checks++;
                assert ({stat_frame_ok, stat_frame_err} === s) else begin
                    errors++;
                    $error("FAIL stat got %b expected %b", {stat_frame_ok, stat_frame_err}, s);
                end
            end
        end
    end

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(negedge clk);
        rx_dv = dv; rxd = d; rx_er = er;
    endtask

    // Payload of n random bytes followed by FCS; flip_idx selects an FCS byte to corrupt
    task automatic build(input int n, input int flip_idx);
        logic [31:0] c, fcs;
        logic [7:0]  b;
        frm.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            frm.push_back(b);
            c = crc32_next(b, c);
        end
        fcs = ~c;
        for (int k = 0; k < 4; k++) begin
            b = fcs[8*k +: 8];
            if (k == flip_idx) b = b ^ 8'h01;
            frm.push_back(b);
        end
    endtask

    task automatic send(input int npre, input int er_idx);
        for (int i = 0; i < npre; i++) drive(1'b1, PREAMBLE_BYTE, 1'b0);
        drive(1'b1, SFD_BYTE, 1'b0);
        for (int i = 0; i < frm.size(); i++) drive(1'b1, frm[i], i == er_idx);
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic expect_frame(input logic err_in);
        int   l;
        logic err;
        l   = frm.size();
        err = err_in;
`ifdef RX_LEN_CHECK_EN
        if (l < MIN_FRAME_SIZE || l > MAX_FRAME_SIZE) err = 1'b1;
`endif
        for (int i = 0; i <= l - 5; i++)
            exp_q.push_back('{frm[i], i == 0, i == l - 5, (i == l - 5) && err});
        stat_q.push_back(err ? 2'b01 : 2'b10);
    endtask

    task automatic drain(input string tag);
        repeat (4) @(negedge clk);
        checks++;
        assert (exp_q.size() == 0 && stat_q.size() == 0) else begin
            errors++;
            $error("FAIL %s leftover got %0d/%0d expected 0/0", tag, exp_q.size(), stat_q.size());
        end
        exp_q.delete();
        stat_q.delete();
    endtask

    initial begin
        #3;
        checks++;
        assert ({out_valid, out_data, out_sop, out_eop, out_err, stat_frame_ok, stat_frame_err} === 14'h0)
        else begin
            errors++;
            $error("FAIL reset_outs got %b%h expected all 0", out_valid, out_data);
        end
        repeat (2) @(negedge clk);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk);

        build(60, -1); expect_frame(1'b0); send(7, -1); drain("good60");
        build(60, 2);  expect_frame(1'b1); send(7, -1); drain("bad_fcs");
        build(60, -1); expect_frame(1'b0); send(6, -1); drain("pre_min6");
        build(20, -1);                     send(5, -1); drain("short_pre");
        build(60, -1); expect_frame(1'b0); send(7, -1); drain("after_short_pre");

        frm.delete();
        frm.push_back(8'h11); frm.push_back(8'h22); frm.push_back(8'h33);
        stat_q.push_back(2'b01); send(7, -1); drain("runt3");

        build(64, -1); expect_frame(1'b1); send(7, 10); drain("rx_er");
        build(1, -1);  expect_frame(1'b0); send(7, -1); drain("single_byte");

        // Abort at payload byte 20: bytes 0..15 are out before the reset hits
        build(60, -1);
        for (int i = 0; i <= 15; i++) exp_q.push_back('{frm[i], i == 0, 1'b0, 1'b0});
        for (int i = 0; i < 7; i++) drive(1'b1, PREAMBLE_BYTE, 1'b0);
        drive(1'b1, SFD_BYTE, 1'b0);
        for (int i = 0; i <= 20; i++) drive(1'b1, frm[i], 1'b0);
        @(negedge clk);
        #1 rst_n_in = 1'b0;
        #1;
        checks++;
        assert ({out_valid, out_eop, out_data, stat_frame_ok, stat_frame_err} === 12'h0) else begin
            errors++;
            $error("FAIL async_reset got %b%b%h expected 0", out_valid, out_eop, out_data);
        end
        rx_dv = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_in = 1'b1;
        drain("reset_abort");

        build(60, -1); expect_frame(1'b0); send(7, -1); drain("after_reset");
        build(40, -1); expect_frame(1'b0); send(7, -1); drain("len40");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
